// File: rtl/demux1to2_buf.sv
`default_nettype none
// ============================================================================
// Module   : demux1to2_buf
// Brief    : 1-to-2 demultiplexer with a small FIFO on each output channel.
//            Optional per-channel push counters behind macro DEMUX_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module demux1to2_buf #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 2,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             ctrl,
    input  logic [WIDTH-1:0] in_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic [CNTW-1:0]  cnt1,
    output logic [CNTW-1:0]  cnt2
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    logic [1:0]       w_full;
    logic [1:0]       w_valid;
    logic [1:0]       w_push;
    logic [1:0]       w_pop;
    logic [1:0]       w_rdy;
    logic [WIDTH-1:0] w_head [2];

    assign w_rdy    = {out2_ready, out1_ready};
    // Depends only on ctrl and registered occupancy, never on the consumers.
    assign in_ready = ~w_full[ctrl];

    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [c_PW-1:0]  r_wr;
        logic [c_PW-1:0]  r_rd;
        logic [c_CW-1:0]  r_cnt;

        assign w_full[g]  = (r_cnt == c_FULL);
        assign w_valid[g] = (r_cnt != '0);
        assign w_push[g]  = in_valid & ~w_full[g] & (ctrl == 1'(g));
        assign w_pop[g]   = w_valid[g] & w_rdy[g];
        // Gating by occupancy makes the head read as zero the moment reset hits.
        assign w_head[g]  = w_valid[g] ? r_mem[r_rd] : '0;

        always_ff @(posedge clk) begin
            if (w_push[g]) begin
                r_mem[r_wr] <= in_data;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_wr  <= '0;
                r_rd  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push[g]) begin
                    r_wr <= r_wr + 1'b1;
                end
                if (w_pop[g]) begin
                    r_rd <= r_rd + 1'b1;
                end
                case ({w_push[g], w_pop[g]})
                    2'b10:   r_cnt <= r_cnt + 1'b1;
                    2'b01:   r_cnt <= r_cnt - 1'b1;
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

    assign out1_valid = w_valid[0];
    assign out1_data  = w_head[0];
    assign out2_valid = w_valid[1];
    assign out2_data  = w_head[1];

`ifdef DEMUX_STATS_EN
    logic [CNTW-1:0] r_cnt1;
    logic [CNTW-1:0] r_cnt2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt1 <= '0;
            r_cnt2 <= '0;
        end else begin
            if (w_push[0]) begin
                r_cnt1 <= r_cnt1 + 1'b1;
            end
            if (w_push[1]) begin
                r_cnt2 <= r_cnt2 + 1'b1;
            end
        end
    end

    assign cnt1 = r_cnt1;
    assign cnt2 = r_cnt2;
`else
    assign cnt1 = '0;
    assign cnt2 = '0;
`endif

endmodule
`default_nettype wire
